// File: rtl/hard_mem_1rw_byte_mask_stream_adapter_pkg.sv
// Shared types and sizing helpers for the ready/valid front-end of the 1rw byte-masked SRAM.
`ifndef HARD_MEM_1RW_BYTE_MASK_STREAM_ADAPTER_PKG_SV
`define HARD_MEM_1RW_BYTE_MASK_STREAM_ADAPTER_PKG_SV

`define DECLARE_HARD_MEM_STREAM_REQ_T(width_mp, els_mp) \
    typedef struct packed { \
        logic                          w; \
        logic [$clog2(els_mp)-1:0]     addr; \
        logic [(width_mp)-1:0]         data; \
        logic [((width_mp)>>3)-1:0]    write_mask; \
    } stream_req_t

package hard_mem_1rw_byte_mask_stream_adapter_pkg;

    localparam int unsigned default_width_lp    = 32'd64;
    localparam int unsigned default_els_lp      = 32'd512;
    localparam int unsigned default_fifo_els_lp = 32'd3;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 32'd2) ? 32'd1 : $clog2(depth);
    endfunction

endpackage

`endif

// File: rtl/hard_mem_stream_resp_fifo.sv
// Register FIFO holding captured SRAM read results; depth need not be a power of two.
module hard_mem_stream_resp_fifo
    import hard_mem_1rw_byte_mask_stream_adapter_pkg::*;
#(
    parameter int unsigned width_p = default_width_lp,
    parameter int unsigned els_p   = default_fifo_els_lp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_width_lp   = ptr_width(els_p);
    localparam int unsigned count_width_lp = count_width(els_p);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_r;
    logic [ptr_width_lp-1:0]   rd_ptr_r;
    logic [count_width_lp-1:0] count_r;
    logic [count_width_lp-1:0] count_n_s;

    function automatic logic [ptr_width_lp-1:0] ptr_incr(input logic [ptr_width_lp-1:0] ptr);
        return ptr_width_lp'((32'(ptr) + 32'd1) % els_p);
    endfunction

    // Occupancy next-state from simultaneous enqueue/dequeue.
    always_comb begin
        count_n_s = count_r;
        case ({v_i, yumi_i})
            2'b10:   count_n_s = count_r + count_width_lp'(1'b1);
            2'b01:   count_n_s = count_r - count_width_lp'(1'b1);
            default: count_n_s = count_r;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (v_i) begin
                wr_ptr_r <= ptr_incr(wr_ptr_r);
            end
            if (yumi_i) begin
                rd_ptr_r <= ptr_incr(rd_ptr_r);
            end
            count_r <= count_n_s;
        end
    end

    // Storage array.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                mem_r[i] <= '0;
            end
        end else if (v_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    assign v_o    = (count_r != '0);
    assign data_o = mem_r[rd_ptr_r];

endmodule

// File: rtl/hard_mem_1rw_byte_mask_stream_adapter.sv
// Ready/valid front-end for the 1rw byte-masked SRAM: forwards requests combinationally and
// captures read data into a credit-managed response FIFO so backpressure never drops a result.
module hard_mem_1rw_byte_mask_stream_adapter_chk #(
    parameter int unsigned credit_width_p = 32'd2,
    parameter int unsigned fifo_els_p     = 32'd3
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    input logic                      yumi_i,
    input logic                      v_o,
    input logic [credit_width_p-1:0] credit_r
);

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
    credit_bounded:   assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       32'(credit_r) <= fifo_els_p);

endmodule

module hard_mem_1rw_byte_mask_stream_adapter
    import hard_mem_1rw_byte_mask_stream_adapter_pkg::*;
#(
    parameter  int unsigned width_p       = default_width_lp,
    parameter  int unsigned els_p         = default_els_lp,
    parameter  int unsigned fifo_els_p    = default_fifo_els_lp,
    localparam int unsigned addr_width_lp = $clog2(els_p),
    localparam int unsigned mask_width_lp = width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [mask_width_lp-1:0] mem_write_mask_o,
    input  logic [width_p-1:0]       mem_data_i
);

    localparam int unsigned              credit_width_lp = count_width(fifo_els_p);
    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(fifo_els_p);

    `DECLARE_HARD_MEM_STREAM_REQ_T(width_p, els_p);

    stream_req_t                req_s;
    logic                       en_r;
    logic                       inflight_r;
    logic [credit_width_lp-1:0] credit_r;
    logic [credit_width_lp-1:0] credit_n_s;
    logic                       accept_s;
    logic                       read_accept_s;
    logic                       deq_s;
    logic                       fifo_v_s;

    assign req_s = '{w: w_i, addr: addr_i, data: data_i, write_mask: write_mask_i};

    // en_r makes reset release visible only from the next clock edge.
    assign ready_o       = en_r & (credit_r < credit_max_lp);
    assign accept_s      = v_i & ready_o;
    assign read_accept_s = accept_s & ~req_s.w;
    assign deq_s         = yumi_i & fifo_v_s;

    assign mem_v_o          = accept_s;
    assign mem_w_o          = req_s.w;
    assign mem_addr_o       = req_s.addr;
    assign mem_data_o       = req_s.data;
    assign mem_write_mask_o = req_s.write_mask;

    // A credit covers both a buffered response and the read still in the SRAM pipeline.
    always_comb begin
        credit_n_s = credit_r;
        case ({read_accept_s, deq_s})
            2'b10:   credit_n_s = credit_r + credit_width_lp'(1'b1);
            2'b01:   credit_n_s = credit_r - credit_width_lp'(1'b1);
            default: credit_n_s = credit_r;
        endcase
    end

    // Control state: enable, one-cycle read tracking, credits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_r       <= 1'b0;
            inflight_r <= 1'b0;
            credit_r   <= '0;
        end else begin
            en_r       <= 1'b1;
            inflight_r <= read_accept_s;
            credit_r   <= credit_n_s;
        end
    end

    hard_mem_stream_resp_fifo #(
        .width_p (width_p),
        .els_p   (fifo_els_p)
    ) resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (inflight_r),
        .data_i    (mem_data_i),
        .v_o       (fifo_v_s),
        .data_o    (data_o),
        .yumi_i    (deq_s)
    );

    assign v_o = fifo_v_s;

    hard_mem_1rw_byte_mask_stream_adapter_chk #(
        .credit_width_p (credit_width_lp),
        .fifo_els_p     (fifo_els_p)
    ) chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .yumi_i    (yumi_i),
        .v_o       (v_o),
        .credit_r  (credit_r)
    );

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_stream_adapter.sv
// Randomized and directed bench with an SRAM model and a queue-based reference of the response stream.
module tb_hard_mem_1rw_byte_mask_stream_adapter;

    localparam int W  = 64;
    localparam int E  = 512;
    localparam int AW = 9;
    localparam int MW = 8;
    localparam int D  = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          v_i = 1'b0;
    logic          w_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [W-1:0]  data_i = '0;
    logic [MW-1:0] write_mask_i = '0;
    logic          yumi_i = 1'b0;
    logic          ready_o, v_o, mem_v_o, mem_w_o;
    logic [W-1:0]  data_o, mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic [MW-1:0] mem_write_mask_o;
    logic [W-1:0]  mem_data_i;

    always #5 clk_i = ~clk_i;

    hard_mem_1rw_byte_mask_stream_adapter dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
        .addr_i(addr_i), .data_i(data_i), .write_mask_i(write_mask_i), .v_o(v_o),
        .data_o(data_o), .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_write_mask_o(mem_write_mask_o), .mem_data_i(mem_data_i)
    );

    // Synchronous-read 1rw byte-masked SRAM.
    logic [W-1:0] sram [E] = '{default: '0};
    logic [W-1:0] sram_q = '0;
    assign mem_data_i = sram_q;
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_write_mask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
            end else begin
                sram_q <= sram[mem_addr_o];
            end
        end
    end

    // Reference: memory image plus ordered list of owed responses with the cycle each becomes visible.
    typedef struct { logic [W-1:0] data; int avail; } resp_t;
    resp_t        q[$];
    logic [W-1:0] ref_mem [E] = '{default: '0};
    logic [W-1:0] dut_pops[$];
    int  cyc = 0;
    bit  en_ref = 1'b0;
    int  acc_cnt = 0;
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [MW-1:0] m, input logic yumi_req);
        logic exp_ready, exp_v, acc;
        resp_t r;
        exp_ready = en_ref && (q.size() < D);
        exp_v = (q.size() > 0) && (q[0].avail <= cyc);
        v_i = v; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
        yumi_i = yumi_req && exp_v;
        #1;
        chk("ready_o", ready_o, exp_ready);
        chk("v_o", v_o, exp_v);
        if (exp_v) chk("data_o", data_o, q[0].data);
        acc = v && exp_ready;
        chk("mem_v_o", mem_v_o, acc);
        if (acc) begin
            chk("mem_w_o", mem_w_o, w);
            chk("mem_addr_o", mem_addr_o, a);
            if (w) begin
                chk("mem_data_o", mem_data_o, d);
                chk("mem_mask_o", mem_write_mask_o, m);
            end
        end
        if (yumi_i) dut_pops.push_back(data_o);
        @(posedge clk_i);
        cyc++;
        en_ref = reset_n_i;
        if (yumi_i) void'(q.pop_front());
        if (acc) begin
            acc_cnt++;
            if (!w) begin
                r.data = ref_mem[a];
                r.avail = cyc + 1;
                q.push_back(r);
            end else begin
                for (int b = 0; b < MW; b++)
                    if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic yumi_req);
        step(1'b1, 1'b0, a, 64'h0, 8'h00, yumi_req);
    endtask
    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [MW-1:0] m);
        step(1'b1, 1'b1, a, d, m, 1'b1);
    endtask
    task automatic idle(input logic yumi_req);
        step(1'b0, 1'b0, 9'd0, 64'h0, 8'h00, yumi_req);
    endtask
    task automatic drain();
        for (int i = 0; i < 12 && q.size() > 0; i++) idle(1'b1);
    endtask

    int a0;
    logic [W-1:0] rnd;

    initial begin
        // Reset state
        #1;
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b0);
        chk("rst_mem_v_o", mem_v_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        idle(1'b0);

        // Write then read
        dut_pops.delete();
        wr(9'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd(9'd5, 1'b1);
        drain();
        chk("wr_rd_count", dut_pops.size(), 1);
        if (dut_pops.size() > 0) chk("wr_rd_data", dut_pops[0], 64'h0123_4567_89AB_CDEF);

        // Byte mask
        dut_pops.delete();
        wr(9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rd(9'd7, 1'b1);
        drain();
        if (dut_pops.size() > 0) chk("mask_data", dut_pops[0], 64'h0000_0000_FFFF_FFFF);
        wr(9'd8, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        rd(9'd8, 1'b1);
        drain();

        // Backpressure: only three reads fit
        for (int i = 0; i < 5; i++) wr(AW'(i), 64'hB0B0_0000_0000_0000 | 64'(i), 8'hFF);
        dut_pops.delete();
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) rd(AW'(i), 1'b0);
        chk("bp_accepted", 64'(acc_cnt - a0), 64'd3);
        drain();
        idle(1'b1);
        chk("bp_pops", dut_pops.size(), 3);
        for (int i = 0; i < 3 && i < dut_pops.size(); i++)
            chk("bp_order", dut_pops[i], 64'hB0B0_0000_0000_0000 | 64'(i));

        // Full throughput with random addresses
        dut_pops.delete();
        a0 = acc_cnt;
        for (int i = 0; i < 100; i++) rd(AW'($urandom_range(0, E - 1)), 1'b1);
        chk("thru_accepted", 64'(acc_cnt - a0), 64'd100);
        drain();
        chk("thru_pops", dut_pops.size(), 100);

        // Write-after-read hazard
        dut_pops.delete();
        wr(9'd9, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        rd(9'd9, 1'b1);
        wr(9'd9, 64'h5555_5555_5555_5555, 8'hFF);
        rd(9'd9, 1'b1);
        drain();
        chk("war_pops", dut_pops.size(), 2);
        if (dut_pops.size() > 1) begin
            chk("war_first", dut_pops[0], 64'hAAAA_AAAA_AAAA_AAAA);
            chk("war_second", dut_pops[1], 64'h5555_5555_5555_5555);
        end

        // Random mix on a small address window
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 AW'($urandom_range(0, 15)), rnd, MW'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset mid-operation: two buffered, one in flight
        wr(9'd20, 64'hC0FF_EE00_1234_5678, 8'hFF);
        rd(9'd1, 1'b0);
        rd(9'd2, 1'b0);
        rd(9'd3, 1'b0);
        v_i = 1'b0; yumi_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_v_o", v_o, 1'b0);
        chk("mid_rst_ready_o", ready_o, 1'b0);
        q.delete();
        en_ref = 1'b0;
        repeat (2) begin
            @(posedge clk_i);
            cyc++;
        end
        #1;
        reset_n_i = 1'b1;
        dut_pops.delete();
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        rd(9'd20, 1'b1);
        drain();
        idle(1'b1);
        chk("post_rst_pops", dut_pops.size(), 1);
        if (dut_pops.size() > 0) chk("post_rst_data", dut_pops[0], 64'hC0FF_EE00_1234_5678);
        for (int i = 0; i < 4; i++) rd(AW'(i), 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
